// File: rtl/rsc_pkg.sv
// Shared types and helpers for the recursive systematic convolutional encoder.
// Functions take the code parameters as arguments so any module or bench can reuse them.
package rsc_pkg;

    localparam int unsigned MAX_M   = 8;
    localparam int unsigned MAX_OUT = 8;

    typedef enum logic {IDLE, ENCODE} state_e;

    typedef struct packed {
        logic               a;
        logic [MAX_OUT-1:0] c;
        logic [MAX_M-1:0]   s_next;
    } step_t;

    // One trellis step; s[m-1] is the newest memory bit, tail forces the feedback sum to zero.
    function automatic step_t rsc_step(
        input logic                        u,
        input logic                        tail,
        input logic [MAX_M-1:0]            s,
        input int unsigned                 m,
        input logic [MAX_M:0]              recursive,
        input logic [MAX_OUT-1:0][MAX_M:0] poly
    );
        step_t          r;
        logic [MAX_M:0] mask;
        logic [MAX_M:0] as;
        logic           fb;
        mask     = (MAX_M+1)'((32'd1 << m) - 32'd1);
        fb       = ^(recursive[MAX_M-1:0] & s & mask[MAX_M-1:0]);
        r.a      = tail ? 1'b0 : (u ^ fb);
        as       = ({1'b0, s} & mask) | ((MAX_M+1)'(r.a) << m);
        for (int unsigned k = 0; k < MAX_OUT; k++)
            r.c[k] = ^(poly[k] & as);
        r.s_next = ((s & mask[MAX_M-1:0]) >> 1) | (MAX_M'(r.a) << (m - 1));
        return r;
    endfunction

    function automatic logic [63:0] llr_width_mask(input int unsigned bits);
        return (bits >= 64) ? '1 : ((64'd1 << bits) - 64'd1);
    endfunction

    function automatic logic [63:0] llr_pos_pattern(
        input int unsigned bits,
        input string       precision,
        input real         amplitude
    );
        logic [63:0] d;
        logic [63:0] r;
        longint      q;
        int          e;
        if (precision == "FIXED") begin
            q = longint'(amplitude);
            r = q;
        end else begin
            // Narrow the double encoding to single precision, rounding on the first dropped bit.
            d = $realtobits(amplitude);
            if (d[62:0] == '0) begin
                r = {32'h0, d[63], 31'h0};
            end else begin
                e = int'(d[62:52]) - 1023 + 127;
                r = {32'h0, d[63], e[7:0], d[51:29]} + 64'(d[28]);
            end
        end
        return r & llr_width_mask(bits);
    endfunction

    function automatic logic [63:0] llr_neg_pattern(
        input int unsigned bits,
        input string       precision,
        input real         amplitude
    );
        logic [63:0] p;
        p = llr_pos_pattern(bits, precision, amplitude);
        if (precision == "FIXED")
            return (-p) & llr_width_mask(bits);
        return p ^ (64'd1 << (bits - 1));
    endfunction

endpackage

// File: rtl/rsc_encoder_llr_step.sv
// Combinational single trellis step of the RSC code (module rsc_trellis_step).
// Kept standalone so the turbo encoder tail generator can share it.
module rsc_trellis_step
    import rsc_pkg::*;
#(
    parameter int unsigned M         = 2,
    parameter int unsigned NOUT      = 2,
    parameter int unsigned RECURSIVE = 7,
    parameter int          POLY [NOUT] = '{5, 7}
) (
    input  logic            u,
    input  logic            tail,
    input  logic [M-1:0]    s,
    output logic [NOUT-1:0] c,
    output logic [M-1:0]    s_next
);

    logic [MAX_OUT-1:0][MAX_M:0] poly_p;
    step_t                       r;
    logic                        unused_bits;

    always_comb begin
        poly_p = '0;
        for (int unsigned k = 0; k < NOUT; k++)
            poly_p[k] = (MAX_M+1)'(POLY[k]);
        r      = rsc_step(u, tail, MAX_M'(s), M, (MAX_M+1)'(RECURSIVE), poly_p);
        c      = r.c[NOUT-1:0];
        s_next = r.s_next[M-1:0];
    end

    assign unused_bits = ^r;

endmodule

// File: rtl/rsc_encoder_llr.sv
// Serial RSC block encoder: one trellis step per clock, emitting coded bits
// and their antipodal LLR words column by column.
module rsc_encoder_llr
    import rsc_pkg::*;
#(
    parameter int unsigned BITS            = 32,
    parameter string       PRECISION       = "SINGLE",
    parameter int unsigned BITS_PER_SYMBOL = 2,
    parameter int unsigned SYMBOLS         = 5,
    parameter int unsigned STATES          = 4,
    parameter int unsigned RECURSIVE       = 7,
    parameter int          POLY [BITS_PER_SYMBOL] = '{5, 7},
    parameter bit          TERMINATE       = 1'b0,
    parameter real         AMPLITUDE       = 2.0
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic                                           in_valid,
    output logic                                           in_ready,
    input  logic [SYMBOLS-1:0]                             in_data,
    output logic                                           out_valid,
    output logic [BITS_PER_SYMBOL-1:0][SYMBOLS-1:0][BITS-1:0] LLRVector,
    output logic [BITS_PER_SYMBOL-1:0][SYMBOLS-1:0]        coded_bits,
    output logic [$clog2(STATES)-1:0]                      final_state
);

    localparam int unsigned M  = $clog2(STATES);
    localparam int unsigned JW = (SYMBOLS > 1) ? $clog2(SYMBOLS) : 1;
    localparam logic [BITS-1:0] LLR_POS = BITS'(llr_pos_pattern(BITS, PRECISION, AMPLITUDE));
    localparam logic [BITS-1:0] LLR_NEG = BITS'(llr_neg_pattern(BITS, PRECISION, AMPLITUDE));
    localparam logic [JW-1:0]   LAST       = JW'(SYMBOLS - 1);
    localparam logic [JW-1:0]   TAIL_START = TERMINATE ? JW'(SYMBOLS - M) : '0;

    state_e                     state, state_next;
    logic [M-1:0]               s, s_next;
    logic [JW-1:0]              j;
    logic [SYMBOLS-1:0]         data;
    logic [BITS_PER_SYMBOL-1:0] c;
    logic                       tail;
    logic                       last_step;

    assign tail      = TERMINATE && (j >= TAIL_START);
    assign last_step = (state == ENCODE) && (j == LAST);

    rsc_trellis_step #(
        .M         (M),
        .NOUT      (BITS_PER_SYMBOL),
        .RECURSIVE (RECURSIVE),
        .POLY      (POLY)
    ) u_step (
        .u      (data[j]),
        .tail   (tail),
        .s      (s),
        .c      (c),
        .s_next (s_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_next = ENCODE;
            end
            ENCODE: begin
                if (j == LAST)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s           <= '0;
            j           <= '0;
            data        <= '0;
            coded_bits  <= '0;
            LLRVector   <= {(BITS_PER_SYMBOL * SYMBOLS){LLR_POS}};
            final_state <= '0;
            out_valid   <= 1'b0;
        end else begin
            out_valid <= last_step;
            if (state == IDLE && in_valid) begin
                data <= in_data;
                s    <= '0;
                j    <= '0;
            end else if (state == ENCODE) begin
                s <= s_next;
                j <= last_step ? '0 : j + JW'(1);
                for (int unsigned k = 0; k < BITS_PER_SYMBOL; k++) begin
                    coded_bits[k][j] <= c[k];
                    LLRVector[k][j]  <= c[k] ? LLR_NEG : LLR_POS;
                end
                if (last_step)
                    final_state <= s_next;
            end
        end
    end

endmodule

// File: tb/tb_rsc_encoder_llr.sv
// Self-checking bench for rsc_encoder_llr: default, terminated and fixed-point builds.
module tb_rsc_encoder_llr;

    typedef logic [1:0][4:0]        cb_t;
    typedef logic [1:0][4:0][31:0]  llr_t;
    typedef logic [1:0][4:0][15:0]  llrf_t;
    typedef struct {
        cb_t        cb;
        logic [1:0] fs;
    } exp_t;

    logic clk, rst_n;

    logic       in_valid, in_ready, out_valid;
    logic [4:0] in_data;
    llr_t       llr;
    cb_t        coded;
    logic [1:0] fstate;

    logic       in_valid_t, in_ready_t, out_valid_t;
    logic [4:0] in_data_t;
    llr_t       llr_t_o;
    cb_t        coded_t;
    logic [1:0] fstate_t;

    logic       in_valid_f, in_ready_f, out_valid_f;
    logic [4:0] in_data_f;
    llrf_t      llr_f;
    cb_t        coded_f;
    logic [1:0] fstate_f;

    int   checks = 0;
    int   fails  = 0;
    exp_t sb[$];

    rsc_encoder_llr dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .LLRVector(llr),
        .coded_bits(coded), .final_state(fstate)
    );

    rsc_encoder_llr #(.TERMINATE(1'b1)) dut_t (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_t), .in_ready(in_ready_t),
        .in_data(in_data_t), .out_valid(out_valid_t), .LLRVector(llr_t_o),
        .coded_bits(coded_t), .final_state(fstate_t)
    );

    rsc_encoder_llr #(.BITS(16), .PRECISION("FIXED")) dut_f (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_f), .in_ready(in_ready_f),
        .in_data(in_data_f), .out_valid(out_valid_f), .LLRVector(llr_f),
        .coded_bits(coded_f), .final_state(fstate_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Independent bit-level model for R=7, polys {5,7}, M=2, 5 steps.
    function automatic exp_t model(input logic [4:0] d, input bit term);
        exp_t e;
        logic s1, s0, a;
        s1 = 1'b0;
        s0 = 1'b0;
        e.cb = '0;
        for (int j = 0; j < 5; j++) begin
            a = (term && j >= 3) ? 1'b0 : (d[j] ^ s1 ^ s0);
            e.cb[0][j] = a ^ s0;
            e.cb[1][j] = a ^ s1 ^ s0;
            s0 = s1;
            s1 = a;
        end
        e.fs = {s1, s0};
        return e;
    endfunction

    function automatic llr_t llr_of(input cb_t cb);
        llr_t l;
        for (int k = 0; k < 2; k++)
            for (int j = 0; j < 5; j++)
                l[k][j] = cb[k][j] ? 32'hC000_0000 : 32'h4000_0000;
        return l;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (coded !== '0) begin fails++; $display("FAIL reset_coded got=%h exp=0", coded); end
        checks++; if (fstate !== 2'b00) begin fails++; $display("FAIL reset_final_state got=%b exp=00", fstate); end
        checks++; if (llr !== {10{32'h4000_0000}}) begin fails++; $display("FAIL reset_llr got=%h", llr); end
        checks++; if (llr_f !== {10{16'h0002}}) begin fails++; $display("FAIL reset_llr_fixed got=%h", llr_f); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_unterminated();
        int   lat;
        exp_t e;
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL unterm_ready got=%b exp=1", in_ready); end
        in_data  = 5'b00100;
        in_valid = 1'b1;
        sb.push_back(model(in_data, 1'b0));
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 5'b11111;
        lat = 0;
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            @(posedge clk); #1;
            if (out_valid) lat = c;
        end
        checks++; if (lat != 5) begin fails++; $display("FAIL unterm_latency got=%0d exp=5", lat); end
        if (lat != 0 && sb.size() > 0) begin
            e = sb.pop_front();
            checks++; if (coded !== e.cb) begin fails++; $display("FAIL unterm_model_coded got=%h exp=%h", coded, e.cb); end
        end
        checks++; if (coded[0] !== 5'b11100) begin fails++; $display("FAIL unterm_row0 got=%b exp=11100", coded[0]); end
        checks++; if (coded[1] !== 5'b00100) begin fails++; $display("FAIL unterm_row1 got=%b exp=00100", coded[1]); end
        checks++; if (fstate !== 2'b01) begin fails++; $display("FAIL unterm_final got=%b exp=01", fstate); end
        checks++; if (llr[0] !== {32'hC000_0000, 32'hC000_0000, 32'hC000_0000, 32'h4000_0000, 32'h4000_0000})
            begin fails++; $display("FAIL unterm_llr0 got=%h", llr[0]); end
        checks++; if (llr[1] !== {32'h4000_0000, 32'h4000_0000, 32'hC000_0000, 32'h4000_0000, 32'h4000_0000})
            begin fails++; $display("FAIL unterm_llr1 got=%h", llr[1]); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL unterm_pulse_width got=%b exp=0", out_valid); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (coded !== {5'b00100, 5'b11100} || fstate !== 2'b01)
            begin fails++; $display("FAIL unterm_hold coded=%h final=%b", coded, fstate); end
    endtask

    task automatic test_terminate();
        logic [4:0] pats [2];
        int         lat;
        pats[0] = 5'b00001;
        pats[1] = 5'b11001;
        for (int p = 0; p < 2; p++) begin
            in_data_t  = pats[p];
            in_valid_t = 1'b1;
            @(posedge clk); #1;
            in_valid_t = 1'b0;
            lat = 0;
            for (int c = 1; c <= 20 && lat == 0; c++) begin
                @(posedge clk); #1;
                if (out_valid_t) lat = c;
            end
            checks++; if (lat != 5) begin fails++; $display("FAIL term_latency[%0d] got=%0d exp=5", p, lat); end
            checks++; if (coded_t[0] !== 5'b01111) begin fails++; $display("FAIL term_row0[%0d] got=%b exp=01111", p, coded_t[0]); end
            checks++; if (coded_t[1] !== 5'b01001) begin fails++; $display("FAIL term_row1[%0d] got=%b exp=01001", p, coded_t[1]); end
            checks++; if (fstate_t !== 2'b00) begin fails++; $display("FAIL term_final[%0d] got=%b exp=00", p, fstate_t); end
            checks++; if (llr_t_o !== llr_of({5'b01001, 5'b01111}))
                begin fails++; $display("FAIL term_llr[%0d] got=%h", p, llr_t_o); end
        end
    endtask

    task automatic test_fixed();
        int lat;
        for (int p = 0; p < 2; p++) begin
            in_data_f  = (p == 0) ? 5'b00000 : 5'b00100;
            in_valid_f = 1'b1;
            @(posedge clk); #1;
            in_valid_f = 1'b0;
            lat = 0;
            for (int c = 1; c <= 20 && lat == 0; c++) begin
                @(posedge clk); #1;
                if (out_valid_f) lat = c;
            end
            checks++; if (lat != 5) begin fails++; $display("FAIL fixed_latency[%0d] got=%0d exp=5", p, lat); end
            if (p == 0) begin
                checks++; if (llr_f !== {10{16'h0002}}) begin fails++; $display("FAIL fixed_zero_llr got=%h", llr_f); end
                checks++; if (coded_f !== '0 || fstate_f !== 2'b00)
                    begin fails++; $display("FAIL fixed_zero_bits coded=%h final=%b", coded_f, fstate_f); end
            end else begin
                checks++; if (llr_f[0] !== {16'hFFFE, 16'hFFFE, 16'hFFFE, 16'h0002, 16'h0002})
                    begin fails++; $display("FAIL fixed_llr0 got=%h", llr_f[0]); end
                checks++; if (llr_f[1] !== {16'h0002, 16'h0002, 16'hFFFE, 16'h0002, 16'h0002})
                    begin fails++; $display("FAIL fixed_llr1 got=%h", llr_f[1]); end
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 18; cyc++) begin
            in_data = 5'($urandom);
            checks++; if (in_ready !== ((cyc % 6) == 0))
                begin fails++; $display("FAIL b2b_ready cyc=%0d got=%b exp=%b", cyc, in_ready, (cyc % 6) == 0); end
            if (in_ready) sb.push_back(model(in_data, 1'b0));
            @(posedge clk); #1;
            checks++; if (out_valid !== ((cyc % 6) == 5))
                begin fails++; $display("FAIL b2b_valid cyc=%0d got=%b exp=%b", cyc, out_valid, (cyc % 6) == 5); end
            if (out_valid && sb.size() > 0) begin
                e = sb.pop_front();
                checks++; if (coded !== e.cb || fstate !== e.fs || llr !== llr_of(e.cb))
                    begin fails++; $display("FAIL b2b_data cyc=%0d coded=%h exp=%h final=%b exp=%b", cyc, coded, e.cb, fstate, e.fs); end
            end
        end
        in_valid = 1'b0;
        checks++; if (sb.size() != 0) begin fails++; $display("FAIL b2b_pending got=%0d exp=0", sb.size()); end
        sb.delete();
    endtask

    task automatic test_reset_abort();
        bit   pulse;
        int   lat;
        exp_t e;
        in_data  = 5'b10110;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL abort_busy got=%b exp=0", in_ready); end
        rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
            begin fails++; $display("FAIL abort_idle ready=%b valid=%b", in_ready, out_valid); end
        checks++; if (llr !== {10{32'h4000_0000}} || coded !== '0 || fstate !== 2'b00)
            begin fails++; $display("FAIL abort_clear llr=%h coded=%h", llr, coded); end
        #1;
        rst_n = 1'b1;
        pulse = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (out_valid) pulse = 1'b1;
        end
        checks++; if (pulse !== 1'b0) begin fails++; $display("FAIL abort_no_pulse got=%b exp=0", pulse); end
        in_data  = 5'b01101;
        in_valid = 1'b1;
        e = model(in_data, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            @(posedge clk); #1;
            if (out_valid) lat = c;
        end
        checks++; if (lat != 5 || coded !== e.cb || fstate !== e.fs)
            begin fails++; $display("FAIL abort_next lat=%0d coded=%h exp=%h final=%b exp=%b", lat, coded, e.cb, fstate, e.fs); end
    endtask

    task automatic test_random();
        exp_t e;
        int   lat;
        for (int b = 0; b < 30; b++) begin
            in_data  = 5'($urandom);
            in_valid = 1'b1;
            sb.push_back(model(in_data, 1'b0));
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_data  = 5'($urandom);
            lat = 0;
            for (int c = 1; c <= 20 && lat == 0; c++) begin
                @(posedge clk); #1;
                if (out_valid) lat = c;
            end
            checks++; if (lat != 5) begin fails++; $display("FAIL rand_latency blk=%0d got=%0d exp=5", b, lat); end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++; if (coded !== e.cb || fstate !== e.fs || llr !== llr_of(e.cb))
                    begin fails++; $display("FAIL rand_data blk=%0d coded=%h exp=%h final=%b exp=%b", b, coded, e.cb, fstate, e.fs); end
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        in_valid   = 1'b0; in_data   = '0;
        in_valid_t = 1'b0; in_data_t = '0;
        in_valid_f = 1'b0; in_data_f = '0;
        test_reset();
        test_unterminated();
        test_terminate();
        test_fixed();
        @(posedge clk); #1;
        test_back_to_back();
        @(posedge clk); #1;
        test_reset_abort();
        @(posedge clk); #1;
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
